// File: rtl/dac_pulse_seq_if.sv
// Command handshake between the pulse sequencer and the MCP4822 SPI driver.
interface dac_pulse_seq_if;
   logic        dac_start;
   logic [15:0] dac_data;
   logic        dac_done;

   modport master (output dac_start, output dac_data, input dac_done);
   modport slave  (input dac_start, input dac_data, output dac_done);
endinterface

// File: rtl/dac_pulse_seq.sv
// Pulse-train sequencer: emits amp/hold/base/hold MCP4822 command words N times,
// always finishing with a base write so the DAC rests at the base level.
module dac_pulse_seq #(
   parameter int HOLD_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              trig,
   input  logic              abort,
   input  logic              chan,
   input  logic              gain_1x,
   input  logic [11:0]       amp,
   input  logic [11:0]       base,
   input  logic [HOLD_W-1:0] t_high,
   input  logic [HOLD_W-1:0] t_low,
   input  logic [CNT_W-1:0]  n_pulse,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [CNT_W-1:0]  pulse_idx,
   dac_pulse_seq_if.master   dac
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR_HI   = 3'd1,
      S_HOLD_HI = 3'd2,
      S_WR_LO   = 3'd3,
      S_HOLD_LO = 3'd4,
      S_FIN     = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0]  IDX_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  IDX_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
   localparam logic [HOLD_W-1:0] HOLD_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};

   function automatic logic [15:0] cmd_word(input logic ch, input logic g1, input logic [11:0] code);
      return {ch, 1'b0, g1, 1'b1, code};
   endfunction

   state_t            state_r, state_nx_s;
   logic              chan_r, gain_r, abort_r, pend_r;
   logic [11:0]       amp_r, base_r;
   logic [HOLD_W-1:0] t_high_r, t_low_r, hold_cnt_r, hold_val_s;
   logic [CNT_W-1:0]  n_pulse_r, pulse_idx_r;
   logic              busy_r, done_r, aborted_r, dac_start_r;
   logic [15:0]       dac_data_r, word_s;
   logic              trig_acc_s, issue_hi_s, issue_lo_s, inc_idx_s, hold_load_s;
   logic              wr_done_s, abort_s, busy_st_s, busy_nx_s, fin_s;

   assign wr_done_s = pend_r & dac.dac_done;
   assign abort_s   = abort_r | abort;
   assign busy_st_s = (state_r == S_WR_HI) || (state_r == S_HOLD_HI) ||
                      (state_r == S_WR_LO) || (state_r == S_HOLD_LO);
   assign busy_nx_s = (state_nx_s == S_WR_HI) || (state_nx_s == S_HOLD_HI) ||
                      (state_nx_s == S_WR_LO) || (state_nx_s == S_HOLD_LO);
   assign fin_s     = busy_st_s && (state_nx_s == S_FIN);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state decode and per-cycle control strobes.
   always_comb begin
      state_nx_s  = state_r;
      trig_acc_s  = 1'b0;
      issue_hi_s  = 1'b0;
      issue_lo_s  = 1'b0;
      inc_idx_s   = 1'b0;
      hold_load_s = 1'b0;
      hold_val_s  = HOLD_ZERO;
      case (state_r)
         S_IDLE, S_FIN: begin
            if (trig) begin
               trig_acc_s = 1'b1;
               if (n_pulse != IDX_ZERO) begin
                  state_nx_s = S_WR_HI;
                  issue_hi_s = 1'b1;
               end else begin
                  state_nx_s = S_FIN;
               end
            end else begin
               state_nx_s = S_IDLE;
            end
         end
         S_WR_HI: begin
            if (wr_done_s) begin
               if (abort_s || (t_high_r == HOLD_ZERO)) begin
                  state_nx_s = S_WR_LO;
                  issue_lo_s = 1'b1;
               end else begin
                  state_nx_s  = S_HOLD_HI;
                  hold_load_s = 1'b1;
                  hold_val_s  = t_high_r - HOLD_ONE;
               end
            end else begin
               state_nx_s = S_WR_HI;
            end
         end
         S_HOLD_HI: begin
            if (abort_s || (hold_cnt_r == HOLD_ZERO)) begin
               state_nx_s = S_WR_LO;
               issue_lo_s = 1'b1;
            end else begin
               state_nx_s = S_HOLD_HI;
            end
         end
         S_WR_LO: begin
            if (wr_done_s) begin
               inc_idx_s = 1'b1;
               // Last pulse skips the trailing low hold.
               if (abort_s || ((pulse_idx_r + IDX_ONE) == n_pulse_r)) begin
                  state_nx_s = S_FIN;
               end else if (t_low_r == HOLD_ZERO) begin
                  state_nx_s = S_WR_HI;
                  issue_hi_s = 1'b1;
               end else begin
                  state_nx_s  = S_HOLD_LO;
                  hold_load_s = 1'b1;
                  hold_val_s  = t_low_r - HOLD_ONE;
               end
            end else begin
               state_nx_s = S_WR_LO;
            end
         end
         S_HOLD_LO: begin
            if (abort_s) begin
               state_nx_s = S_FIN;
            end else if (hold_cnt_r == HOLD_ZERO) begin
               state_nx_s = S_WR_HI;
               issue_hi_s = 1'b1;
            end else begin
               state_nx_s = S_HOLD_LO;
            end
         end
         default: begin
            state_nx_s = S_IDLE;
         end
      endcase
   end

   // Command word for the write being issued this cycle.
   always_comb begin
      word_s = dac_data_r;
      if (issue_lo_s) begin
         word_s = cmd_word(chan_r, gain_r, base_r);
      end else if (trig_acc_s) begin
         word_s = cmd_word(chan, gain_1x, amp);
      end else begin
         word_s = cmd_word(chan_r, gain_r, amp_r);
      end
   end

   // Config latch, counters, abort flag and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chan_r      <= 1'b0;
         gain_r      <= 1'b0;
         amp_r       <= 12'h000;
         base_r      <= 12'h000;
         t_high_r    <= HOLD_ZERO;
         t_low_r     <= HOLD_ZERO;
         n_pulse_r   <= IDX_ZERO;
         abort_r     <= 1'b0;
         pend_r      <= 1'b0;
         hold_cnt_r  <= HOLD_ZERO;
         pulse_idx_r <= IDX_ZERO;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         aborted_r   <= 1'b0;
         dac_start_r <= 1'b0;
         dac_data_r  <= 16'h0000;
      end else begin
         if (trig_acc_s) begin
            chan_r      <= chan;
            gain_r      <= gain_1x;
            amp_r       <= amp;
            base_r      <= base;
            t_high_r    <= t_high;
            t_low_r     <= t_low;
            n_pulse_r   <= n_pulse;
            abort_r     <= 1'b0;
            aborted_r   <= 1'b0;
            pulse_idx_r <= IDX_ZERO;
         end else begin
            if (abort && busy_st_s) begin
               abort_r <= 1'b1;
            end
            if (inc_idx_s) begin
               pulse_idx_r <= pulse_idx_r + IDX_ONE;
            end
            if (fin_s) begin
               aborted_r <= abort_s;
            end
         end

         if (hold_load_s) begin
            hold_cnt_r <= hold_val_s;
         end else if (((state_r == S_HOLD_HI) || (state_r == S_HOLD_LO)) && (hold_cnt_r != HOLD_ZERO)) begin
            hold_cnt_r <= hold_cnt_r - HOLD_ONE;
         end

         // A new write may be issued in the same cycle the previous one completes.
         if (issue_hi_s || issue_lo_s) begin
            dac_start_r <= 1'b1;
            dac_data_r  <= word_s;
            pend_r      <= 1'b1;
         end else begin
            dac_start_r <= 1'b0;
            if (wr_done_s) begin
               pend_r <= 1'b0;
            end
         end

         busy_r <= busy_nx_s;
         done_r <= (state_nx_s == S_FIN);
      end
   end

   assign busy          = busy_r;
   assign done          = done_r;
   assign aborted       = aborted_r;
   assign pulse_idx     = pulse_idx_r;
   assign dac.dac_start = dac_start_r;
   assign dac.dac_data  = dac_data_r;

endmodule

// File: tb/tb_dac_pulse_seq.sv
// Scoreboard bench for dac_pulse_seq with an SPI driver model answering 77 cycles after each start.
module tb_dac_pulse_seq;

   typedef struct {
      int          cyc;
      logic [15:0] word;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        trig, abort, chan, gain_1x;
   logic [11:0] amp, base;
   logic [15:0] t_high, t_low, n_pulse;
   logic        busy, done, aborted;
   logic [15:0] pulse_idx;

   dac_pulse_seq_if dac ();

   dac_pulse_seq #(.HOLD_W(16), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .trig(trig), .abort(abort), .chan(chan), .gain_1x(gain_1x),
      .amp(amp), .base(base), .t_high(t_high), .t_low(t_low), .n_pulse(n_pulse),
      .busy(busy), .done(done), .aborted(aborted), .pulse_idx(pulse_idx), .dac(dac)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   int   t0 = 0;
   int   total = 0;
   int   bad = 0;
   int   exp_done, exp_idx;
   logic exp_ab;
   logic got_done;
   exp_t sb[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      if (obs !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (rel cycle %0d)", tag, obs, expv, cyc - t0);
      end
   endtask

   task automatic push(input int c, input logic [15:0] w);
      exp_t e;
      e.cyc  = c;
      e.word = w;
      sb.push_back(e);
   endtask

   // SPI driver model: dac_done exactly 77 cycles after each dac_start.
   initial begin
      logic pend;
      int   due;
      pend = 1'b0;
      due  = 0;
      dac.dac_done = 1'b0;
      forever begin
         @(negedge clk);
         dac.dac_done = pend && (cyc == due);
         if (dac.dac_done) pend = 1'b0;
         if (!rst_n) pend = 1'b0;
         else if (dac.dac_start) begin
            pend = 1'b1;
            due  = cyc + 77;
         end
      end
   end

   // Monitor: pops the scoreboard on every write and checks each train end.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (dac.dac_start) begin
               if (sb.size() == 0) begin
                  check("extra_start", 32'(cyc - t0), 32'hFFFF_FFFF);
               end else begin
                  e = sb.pop_front();
                  check("start_cyc", 32'(cyc - t0), 32'(e.cyc));
                  check("word", 32'(dac.dac_data), 32'(e.word));
               end
            end
            if (done) begin
               check("done_cyc", 32'(cyc - t0), 32'(exp_done));
               check("busy_at_done", 32'(busy), 32'd0);
               check("aborted", 32'(aborted), 32'(exp_ab));
               check("pulse_idx", 32'(pulse_idx), 32'(exp_idx));
               got_done = 1'b1;
            end
         end
      end
   end

   task automatic run(input logic c, input logic g, input logic [11:0] a, input logic [11:0] b,
                      input logic [15:0] th, input logic [15:0] tl, input logic [15:0] np,
                      input int abort_at, input int trig2_at, input int rst_at,
                      input int done_at, input int idx_e, input logic ab_e);
      int limit;
      limit = (rst_at > 0) ? rst_at : done_at + 10;
      @(negedge clk);
      chan = c; gain_1x = g; amp = a; base = b; t_high = th; t_low = tl; n_pulse = np;
      trig = 1'b1;
      t0 = cyc;
      exp_done = done_at; exp_idx = idx_e; exp_ab = ab_e;
      got_done = 1'b0;
      for (int i = 1; i <= limit; i++) begin
         @(negedge clk);
         trig  = 1'b0;
         abort = (i == abort_at);
         if (i == trig2_at) begin
            trig    = 1'b1;
            amp     = 12'hFFF;
            n_pulse = 16'd9;
         end
         if (i == 1) begin
            check("busy_t1", 32'(busy), 32'(np != 16'd0));
            check("idx_t1", 32'(pulse_idx), 32'd0);
            check("aborted_t1", 32'(aborted), 32'd0);
         end
         if (i == rst_at) begin
            rst_n = 1'b0;
            #1;
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_idx", 32'(pulse_idx), 32'd0);
            check("rst_start", 32'(dac.dac_start), 32'd0);
            check("rst_data", 32'(dac.dac_data), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            break;
         end
         if (got_done) break;
      end
      trig  = 1'b0;
      abort = 1'b0;
      if (rst_at < 0) check("done_seen", 32'(got_done), 32'd1);
      repeat (3) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; trig = 1'b0; abort = 1'b0; chan = 1'b0; gain_1x = 1'b0;
      amp = 12'h000; base = 12'h000; t_high = 16'd0; t_low = 16'd0; n_pulse = 16'd0;
      repeat (3) @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_aborted", 32'(aborted), 32'd0);
      check("reset_idx", 32'(pulse_idx), 32'd0);
      check("reset_start", 32'(dac.dac_start), 32'd0);
      check("reset_data", 32'(dac.dac_data), 32'd0);
      rst_n = 1'b1;
      // abort while idle must be ignored
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_abort_busy", 32'(busy), 32'd0);

      // Single train.
      push(1, 16'hB800); push(89, 16'hB000); push(172, 16'hB800); push(260, 16'hB000);
      run(1'b1, 1'b1, 12'h800, 12'h000, 16'd10, 16'd5, 16'd2, -1, -1, -1, 338, 2, 1'b0);

      // Zero holds: each start one cycle after the previous done.
      for (int k = 0; k < 6; k++) push(1 + 78 * k, (k % 2 == 0) ? 16'h1FFF : 16'h1000);
      run(1'b0, 1'b0, 12'hFFF, 12'h000, 16'd0, 16'd0, 16'd3, -1, -1, -1, 469, 3, 1'b0);

      // n_pulse = 0.
      run(1'b0, 1'b1, 12'h555, 12'h111, 16'd4, 16'd4, 16'd0, -1, -1, -1, 1, 0, 1'b0);

      // Abort in HOLD_HI of pulse 1.
      push(1, 16'h3123); push(201, 16'h3045);
      run(1'b0, 1'b1, 12'h123, 12'h045, 16'd1000, 16'd5, 16'd3, 200, -1, -1, 279, 1, 1'b1);

      // Abort during in-flight base write, plus an ignored trig while busy.
      push(1, 16'h90AA); push(82, 16'h9011);
      run(1'b1, 1'b0, 12'h0AA, 12'h011, 16'd3, 16'd4, 16'd2, 120, 130, -1, 160, 1, 1'b1);
      check("aborted_held", 32'(aborted), 32'd1);
      check("idle_after_abort", 32'(busy), 32'd0);

      // Reset in HOLD_HI, then a clean restart.
      push(1, 16'h3123);
      run(1'b0, 1'b1, 12'h123, 12'h045, 16'd1000, 16'd5, 16'd1, -1, -1, 100, 0, 0, 1'b0);
      check("post_rst_aborted", 32'(aborted), 32'd0);
      push(1, 16'h3123); push(81, 16'h3045);
      run(1'b0, 1'b1, 12'h123, 12'h045, 16'd2, 16'd7, 16'd1, -1, -1, -1, 159, 1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
